mdu_hilo_ctrl: RTL and testbench
================================

Name: mdu_hilo_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EXE stage and runs a fixed-latency multiply or a 32-iteration radix-2 restoring divide.
- Holds EXE via a stall request while busy, then commits HI/LO; MFHI/MFLO read HI/LO directly.

Parameters:
- MUL_CYCLES, 4, cycles spent in MUL state before commit (legal range 1..16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- EXE_MDOp  in  4  op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP.
- EXE_BusA  in  32  rs operand (forwarded).
- EXE_BusB  in  32  rt operand (forwarded).
- EXE_Flush  in  1  abort in-flight op / ignore current op (exception, eret).
- MDU_Stall  out  1  hold PC, IF_ID, ID_EXE; bubble EXE_MEM.
- MDU_Done  out  1  one-cycle pulse on HI/LO commit of mul/div.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (rst=0, async): state IDLE, HI=0, LO=0, counter=0, MDU_Stall=0, MDU_Done=0.
- States: IDLE, MUL, DIV, DONE.
- start = (state==IDLE) && !EXE_Flush && op in {1..4} (plus {7..10} with the optional feature).
- IDLE:
  - On start: latch BusA/BusB and the signedness flag; go to MUL (ops 1, 2, 7-10) or DIV (ops 3, 4).
  - MTHI writes HI=BusA; MTLO writes LO=BusA, both at the clock edge of the issue cycle. No stall for these.
- MDU_Stall is combinational: start || state==MUL || state==DIV. The issue cycle itself stalls.
- MUL:
  - Counter runs 0..MUL_CYCLES-1.
  - On the last count: {HI,LO} = 64-bit product (signed for MULT, unsigned for MULTU). Go to DONE.
  - Total stall: 1+MUL_CYCLES cycles.
- DIV:
  - Operate on unsigned magnitudes (abs for DIV); 32 restoring iterations, one per cycle, counter 0..31.
  - On the edge leaving iteration 31: apply sign fix. Quotient is negative iff signs differ; remainder takes the dividend's sign. Write LO=quotient, HI=remainder, go to DONE.
  - Total stall: 33 cycles.
- Divide boundary cases:
  - Divide by zero: LO=0xFFFFFFFF (DIVU) or raw sign-fixed restoring result (DIV); HI=dividend. No exception.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DONE: MDU_Stall=0, MDU_Done=1. The stalled instruction advances this cycle and start is ignored. Next state is IDLE unconditionally.
- Back-to-back: a mul/div can issue in the cycle after DONE. In DONE, HI/LO already hold the new values, so MFHI/MFLO in EXE during DONE reads the new result.
- EXE_Flush:
  - Any state goes to IDLE at the next edge; HI/LO are unchanged; no MDU_Done.
  - In IDLE, flush suppresses start and MTHI/MTLO writes (flush wins over simultaneous start).
- rst asserted mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 7-10 are accepted and use the MUL path with the same latency.
  - Commit is {HI,LO} = {HI,LO} ± product, where {HI,LO} is the value at commit time.
  - Signed for MADD/MSUB, unsigned for MADDU/MSUBU; 64-bit wrap, no overflow flag.
- Undefined: ops 7-10 decode as NOP: no stall and no HI/LO change.

Test Plan:
- Reset low then high; MULT A=0xFFFFFFFE(-2) B=3 with MUL_CYCLES=4 -> Stall high 5 cycles, then DONE with HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulse 1 cycle.
- DIVU A=100 B=7 -> Stall 33 cycles; LO=14, HI=2. DIV A=-7 B=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
- DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV started; EXE_Flush at iteration 10 -> IDLE next cycle, HI/LO keep prior values, no Done. MTHI 0xA5A5A5A5 issued with flush -> HI unchanged.
- MULTU then MTLO 0x55 in the cycle after DONE -> LO=0x55, HI keeps the product high word, no stall on MTLO.
- With MDU_MADD_EN: HI:LO=0:10, MADD A=-1 B=3 -> HI=0, LO=7. Without the macro, the same op -> no stall, HI:LO unchanged.

Source files
------------

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   EXE_MDOp  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//               7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (7-10 need MDU_MADD_EN)
//   EXE_BusA  - rs operand, EXE_BusB - rt operand
//   EXE_Flush - abort in-flight op / ignore current op
//   MDU_Stall - hold the front of the pipe while an op is issuing or running
//   MDU_Done  - one-cycle pulse when a mul/div result lands in HI/LO
//   HI, LO    - architectural HI/LO registers
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_hilo_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_MDOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Flush,
    output logic        MDU_Stall,
    output logic        MDU_Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d;
`ifdef MDU_MADD_EN
    logic        acc_q, acc_d, sub_q, sub_d;
`endif

    logic        op_mul, op_div, op_sgn, start;
    logic [31:0] abs_a, abs_b, quo_n, rem_n;
    logic [32:0] shl, diff;
    logic [63:0] ax, bx, prod, mul_res;

    always_comb begin
`ifdef MDU_MADD_EN
        op_mul = EXE_MDOp == 4'd1 || EXE_MDOp == 4'd2 || (EXE_MDOp >= 4'd7 && EXE_MDOp <= 4'd10);
`else
        op_mul = EXE_MDOp == 4'd1 || EXE_MDOp == 4'd2;
`endif
        op_div = EXE_MDOp == 4'd3 || EXE_MDOp == 4'd4;
        op_sgn = EXE_MDOp == 4'd1 || EXE_MDOp == 4'd3 || EXE_MDOp == 4'd7 || EXE_MDOp == 4'd9;
        start  = state_q == IDLE && !EXE_Flush && (op_mul || op_div);
        abs_a  = (op_sgn && EXE_BusA[31]) ? -EXE_BusA : EXE_BusA;
        abs_b  = (op_sgn && EXE_BusB[31]) ? -EXE_BusB : EXE_BusB;
        // 64-bit truncated product of sign/zero-extended operands is exact in both modes
        ax     = {{32{sgn_q & a_q[31]}}, a_q};
        bx     = {{32{sgn_q & b_q[31]}}, b_q};
        prod   = ax * bx;
`ifdef MDU_MADD_EN
        mul_res = !acc_q ? prod : sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
`else
        mul_res = prod;
`endif
        // restoring step: a_q shifts the dividend out and the quotient in
        shl    = {rem_q, a_q[31]};
        diff   = shl - {1'b0, b_q};
        rem_n  = diff[32] ? shl[31:0] : diff[31:0];
        quo_n  = {a_q[30:0], ~diff[32]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`ifdef MDU_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif
        if (EXE_Flush) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = op_div ? DIV : MUL;
                        cnt_d   = 5'd0;
                        a_d     = op_div ? abs_a : EXE_BusA;
                        b_d     = op_div ? abs_b : EXE_BusB;
                        rem_d   = 32'd0;
                        sgn_d   = op_sgn;
                        negq_d  = op_sgn & (EXE_BusA[31] ^ EXE_BusB[31]);
                        negr_d  = op_sgn & EXE_BusA[31];
`ifdef MDU_MADD_EN
                        acc_d   = EXE_MDOp >= 4'd7;
                        sub_d   = EXE_MDOp >= 4'd9;
`endif
                    end else if (EXE_MDOp == 4'd5) begin
                        hi_d = EXE_BusA;
                    end else if (EXE_MDOp == 4'd6) begin
                        lo_d = EXE_BusA;
                    end
                end
                MUL: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                        {hi_d, lo_d} = mul_res;
                        state_d      = DONE;
                    end
                end
                DIV: begin
                    a_d   = quo_n;
                    rem_d = rem_n;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        lo_d    = negq_q ? -quo_n : quo_n;
                        hi_d    = negr_q ? -rem_n : rem_n;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign MDU_Stall = start || state_q == MUL || state_q == DIV;
    assign MDU_Done  = state_q == DONE;
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: scoreboard bench for mdu_hilo_ctrl against an arithmetic reference model.
module tb_mdu_hilo_ctrl;
    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  EXE_MDOp = 4'd0;
    logic [31:0] EXE_BusA = 32'd0;
    logic [31:0] EXE_BusB = 32'd0;
    logic        EXE_Flush = 1'b0;
    logic        MDU_Stall, MDU_Done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_hilo_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .EXE_MDOp(EXE_MDOp), .EXE_BusA(EXE_BusA),
        .EXE_BusB(EXE_BusB), .EXE_Flush(EXE_Flush), .MDU_Stall(MDU_Stall),
        .MDU_Done(MDU_Done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic bit accepted(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
        return op >= 4'd1 && op <= 4'd4;
`endif
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] hilo);
        logic [63:0] ps, pu;
        int sa, sb;
        ps = longint'($signed(a)) * longint'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        sa = a;
        sb = b;
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            4'd7: return hilo + ps;
            4'd8: return hilo + pu;
            4'd9: return hilo - ps;
            4'd10: return hilo - pu;
            default: return hilo;
        endcase
    endfunction

    // Issue one op at a negedge; for mul/div it stays in EXE while stalled.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [63:0] r;
        @(negedge clk);
        EXE_MDOp = op; EXE_BusA = a; EXE_BusB = b; EXE_Flush = 1'b0;
        #1;
        if (accepted(op)) begin
            r = model(op, a, b, {m_hi, m_lo});
            {m_hi, m_lo} = r;
            exp_q.push_back(r);
            cyc = 0;
            while (MDU_Stall && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            EXE_MDOp = 4'd0;
            chk("stall_cycles", cyc, (op == 4'd3 || op == 4'd4) ? 33 : 1 + MUL_CYCLES);
        end else begin
            chk("no_stall", {31'd0, MDU_Stall}, 0);
            if (op == 4'd5) m_hi = a;
            if (op == 4'd6) m_lo = a;
            @(posedge clk);
            #1;
            EXE_MDOp = 4'd0;
            chk("hi_direct", HI, m_hi);
            chk("lo_direct", LO, m_lo);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && MDU_Done) begin
                chk("done_width", {31'd0, prev}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hi", HI, e[63:32]);
                    chk("sb_lo", LO, e[31:0]);
                end
            end
            prev = MDU_Done;
        end
    end

    initial begin
        logic [31:0] hi0, lo0, a, b;
        logic [3:0] op;
        #2;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_stall", {31'd0, MDU_Stall}, 0);
        chk("rst_done", {31'd0, MDU_Done}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        issue(4'd4, 32'd100, 32'd7);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);
        issue(4'd3, -32'd7, 32'd2);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        issue(4'd4, 32'h1234, 32'd0);
        chk("divz_lo", LO, 32'hFFFFFFFF);
        chk("divz_hi", HI, 32'h1234);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("divov_lo", LO, 32'h80000000);
        chk("divov_hi", HI, 32'd0);

        // flush a divide during iteration 10
        hi0 = m_hi; lo0 = m_lo;
        @(negedge clk);
        EXE_MDOp = 4'd3; EXE_BusA = 32'd1000; EXE_BusB = 32'd3;
        repeat (11) @(negedge clk);
        EXE_Flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_stall", {31'd0, MDU_Stall}, 0);
        chk("flush_done", {31'd0, MDU_Done}, 0);
        EXE_Flush = 1'b0; EXE_MDOp = 4'd0;
        repeat (3) @(negedge clk);
        chk("flush_hi", HI, hi0);
        chk("flush_lo", LO, lo0);

        // MTHI with simultaneous flush is dropped
        @(negedge clk);
        EXE_MDOp = 4'd5; EXE_BusA = 32'hA5A5A5A5; EXE_Flush = 1'b1;
        @(posedge clk);
        #1;
        chk("mthi_flush_hi", HI, hi0);
        EXE_MDOp = 4'd0; EXE_Flush = 1'b0;

        // MULTU then MTLO in the cycle after DONE
        issue(4'd2, 32'hDEADBEEF, 32'h12345678);
        issue(4'd6, 32'h55, 32'd0);
        chk("mtlo_lo", LO, 32'h55);

        // MADD: in the default build this is a NOP
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        issue(4'd7, 32'hFFFFFFFF, 32'd3);
`ifdef MDU_MADD_EN
        chk("madd_lo", LO, 32'd7);
`else
        chk("madd_lo", LO, 32'd10);
`endif
        chk("madd_hi", HI, 32'd0);

        // reset in the middle of a multiply
        @(negedge clk);
        EXE_MDOp = 4'd1; EXE_BusA = 32'd9; EXE_BusB = 32'd9;
        repeat (2) @(negedge clk);
        EXE_MDOp = 4'd0;
        rst = 1'b0;
        #1;
        chk("midrst_hi", HI, 0);
        chk("midrst_lo", LO, 0);
        chk("midrst_stall", {31'd0, MDU_Stall}, 0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            issue(op, a, b);
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
